// File: rtl/pe_pkg.sv
// pe_pkg
// Shared constants and types for the vector MAC processing element.
// Holds the default lane count and element/offset/accumulator widths,
// the width of the beat counters, and the two-state output register
// encoding used by pe_vec.
// Ports: none (package).
package pe_pkg;

    localparam int LANES_DEF = 4;
    localparam int DW_DEF    = 8;
    localparam int OW_DEF    = 9;
    localparam int AW_DEF    = 32;
    localparam int CNT_W     = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/pe_vec_if.sv
// pe_vec_if
// Bundles the beat input stream, the systolic forwarding outputs and the
// result handshake of pe_vec into one interface.
// Ports (by modport):
//   slave  (the PE):   in  input_offset, ifmap, weight, in_valid, in_last,
//                          clear, out_ready
//                      out in_ready, ifmap_out, weight_out, fwd_valid,
//                          fwd_last, ofmap, out_valid, ofmap_cnt, sat_flag
//   master (the driver): the same signals with opposite directions.
interface pe_vec_if
    import pe_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int DW    = DW_DEF,
    parameter int OW    = OW_DEF,
    parameter int AW    = AW_DEF
);

    logic [OW-1:0]       input_offset;
    logic [LANES*DW-1:0] ifmap;
    logic [LANES*DW-1:0] weight;
    logic                in_valid;
    logic                in_last;
    logic                in_ready;
    logic                clear;
    logic [LANES*DW-1:0] ifmap_out;
    logic [LANES*DW-1:0] weight_out;
    logic                fwd_valid;
    logic                fwd_last;
    logic [AW-1:0]       ofmap;
    logic                out_valid;
    logic                out_ready;
    logic [CNT_W-1:0]    ofmap_cnt;
    logic                sat_flag;

    modport slave (
        input  input_offset, ifmap, weight, in_valid, in_last, clear, out_ready,
        output in_ready, ifmap_out, weight_out, fwd_valid, fwd_last,
               ofmap, out_valid, ofmap_cnt, sat_flag
    );

    modport master (
        output input_offset, ifmap, weight, in_valid, in_last, clear, out_ready,
        input  in_ready, ifmap_out, weight_out, fwd_valid, fwd_last,
               ofmap, out_valid, ofmap_cnt, sat_flag
    );

endinterface

// File: rtl/pe_lane_mul.sv
// pe_lane_mul
// One MAC lane: term = ifmap*weight + input_offset*weight, all signed.
// Every operand is sign-extended to the accumulator width first, so each
// product is the AW-bit two's-complement value of the true product.
// Ports:
//   ifmap        in  DW  signed ifmap element
//   weight       in  DW  signed weight element
//   input_offset in  OW  signed offset added to the ifmap element
//   term         out AW  lane contribution to the beat sum
module pe_lane_mul
    import pe_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int OW = OW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic signed [DW-1:0] ifmap,
    input  logic signed [DW-1:0] weight,
    input  logic signed [OW-1:0] input_offset,
    output logic signed [AW-1:0] term
);

    logic signed [AW-1:0] ifmap_x;
    logic signed [AW-1:0] weight_x;
    logic signed [AW-1:0] offset_x;

    always_comb begin
        ifmap_x  = AW'(ifmap);
        weight_x = AW'(weight);
        offset_x = AW'(input_offset);
        term     = (ifmap_x * weight_x) + (offset_x * weight_x);
    end

endmodule

// File: rtl/pe_vec.sv
// pe_vec
// Vector MAC processing element. Each accepted beat adds the sum of LANES
// lane terms to an accumulator; the beat flagged in_last moves the finished
// dot product into a one-entry output register (EMPTY/FULL) and restarts
// the accumulation. Accepted beats are also forwarded one cycle later for
// systolic chaining. rst_n is a synchronous, active-high reset.
// Optional feature: define PE_ACC_SAT_EN to clamp accumulator updates to
// the signed AW-bit range and raise a sticky sat_flag; otherwise the
// accumulator wraps and sat_flag is tied low.
// Ports:
//   clk    in  sole clock, rising edge
//   rst_n  in  synchronous reset, asserted high
//   bus    pe_vec_if.slave  beat stream, forwarding outputs, result handshake
module pe_vec
    import pe_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int DW    = DW_DEF,
    parameter int OW    = OW_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    pe_vec_if.slave  bus
);

    logic signed [AW-1:0] lane_term [LANES];
    logic signed [AW-1:0] term;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_sum;
    logic signed [AW-1:0] ofmap;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_inc;
    logic [CNT_W-1:0]     ofmap_cnt;
    logic [LANES*DW-1:0]  ifmap_out;
    logic [LANES*DW-1:0]  weight_out;
    logic                 fwd_valid;
    logic                 fwd_last;
    logic                 in_ready;
    logic                 accept;
    out_state_t           state;
    out_state_t           state_next;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pe_lane_mul #(.DW(DW), .OW(OW), .AW(AW)) u_mul (
            .ifmap        (bus.ifmap[i*DW +: DW]),
            .weight       (bus.weight[i*DW +: DW]),
            .input_offset (bus.input_offset),
            .term         (lane_term[i])
        );
    end

    always_comb begin
        term = '0;
        for (int i = 0; i < LANES; i++) begin
            term = term + lane_term[i];
        end
    end

    // A FULL result blocks new beats unless it is being taken this cycle,
    // so a last beat can overwrite it in the same edge it is consumed.
    assign in_ready = !bus.clear && ((state == EMPTY) || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

`ifdef PE_ACC_SAT_EN
    logic [AW:0] wide_sum;
    logic        sum_ovf;
    logic        sat_reg;

    // One extra bit exposes signed overflow; the sign of the wide sum picks
    // which rail to clamp to.
    always_comb begin
        wide_sum = {acc[AW-1], acc} + {term[AW-1], term};
        sum_ovf  = (wide_sum[AW] != wide_sum[AW-1]);
        if (!sum_ovf) begin
            acc_sum = wide_sum[AW-1:0];
        end else if (wide_sum[AW]) begin
            acc_sum = {1'b1, {(AW-1){1'b0}}};
        end else begin
            acc_sum = {1'b0, {(AW-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            sat_reg <= 1'b0;
        end else if (accept && sum_ovf) begin
            sat_reg <= 1'b1;
        end
    end

    assign bus.sat_flag = sat_reg;
`else
    assign acc_sum      = acc + term;
    assign bus.sat_flag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (accept && bus.in_last) begin
            state_next = FULL;
        end else if ((state == FULL) && bus.out_ready) begin
            state_next = EMPTY;
        end
    end

    // clear flushes the accumulation and forwarding path only; a result
    // already in the output register survives it.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            acc        <= '0;
            cnt        <= '0;
            ofmap      <= '0;
            ofmap_cnt  <= '0;
            ifmap_out  <= '0;
            weight_out <= '0;
            fwd_valid  <= 1'b0;
            fwd_last   <= 1'b0;
        end else if (bus.clear) begin
            acc        <= '0;
            cnt        <= '0;
            ifmap_out  <= '0;
            weight_out <= '0;
            fwd_valid  <= 1'b0;
            fwd_last   <= 1'b0;
        end else begin
            fwd_valid <= accept;
            if (accept) begin
                ifmap_out  <= bus.ifmap;
                weight_out <= bus.weight;
                fwd_last   <= bus.in_last;
                if (bus.in_last) begin
                    ofmap     <= acc_sum;
                    ofmap_cnt <= cnt_inc;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt_inc;
                end
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = (state == FULL);
    assign bus.ofmap      = ofmap;
    assign bus.ofmap_cnt  = ofmap_cnt;
    assign bus.ifmap_out  = ifmap_out;
    assign bus.weight_out = weight_out;
    assign bus.fwd_valid  = fwd_valid;
    assign bus.fwd_last   = fwd_last;

endmodule

// File: tb/tb_pe_vec.sv
// tb_pe_vec
// Self-checking bench for pe_vec (LANES=4, DW=8, OW=9, AW=16). A reference
// model computes each dot product with plain integer arithmetic and pushes
// the expected result into a queue; an independent monitor pops and
// compares whenever the DUT hands a result over (out_valid & out_ready).
// Honours PE_ACC_SAT_EN for the saturating-accumulator expectations.
// Ports: none (top-level bench).
module tb_pe_vec;

    localparam int LANES = 4;
    localparam int DW    = 8;
    localparam int OW    = 9;
    localparam int AW    = 16;
    localparam int BW    = LANES * DW;

    typedef struct {
        longint ofmap;
        longint cnt;
    } result_t;

    logic clk = 1'b0;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    result_t exp_q[$];

    longint        m_acc;
    longint        m_cnt;
    bit            m_sat;
    bit            m_full;
    bit            e_fwd_valid;
    bit            e_fwd_last;
    logic [BW-1:0] e_ifm_out;
    logic [BW-1:0] e_wt_out;
    bit            last_acc;

    always #5 clk = ~clk;

    pe_vec_if #(.LANES(LANES), .DW(DW), .OW(OW), .AW(AW)) bus ();

    pe_vec #(.LANES(LANES), .DW(DW), .OW(OW), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Every comparison funnels through here so the counters stay honest.
    task automatic check_output(string name, longint act, longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint wrap_aw(longint v);
        longint m;
        m = v & ((longint'(1) << AW) - 1);
        if (m >= (longint'(1) << (AW - 1))) m = m - (longint'(1) << AW);
        return m;
    endfunction

    // Dot product of one beat: sum of (ifmap_i + offset) * weight_i,
    // reduced to the accumulator width.
    function automatic longint beat_term(logic [BW-1:0] ifm, logic [BW-1:0] wt,
                                         logic [OW-1:0] off);
        longint        sum;
        longint        o;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        sum = 0;
        o   = longint'($signed(off));
        for (int i = 0; i < LANES; i++) begin
            a   = ifm[i*DW +: DW];
            b   = wt[i*DW +: DW];
            sum = sum + (longint'($signed(a)) + o) * longint'($signed(b));
        end
        return wrap_aw(sum);
    endfunction

    function automatic longint add_acc(longint a, longint t, inout bit sat);
        longint s;
        s = a + t;
`ifdef PE_ACC_SAT_EN
        if (s > (longint'(1) << (AW - 1)) - 1) begin
            s   = (longint'(1) << (AW - 1)) - 1;
            sat = 1'b1;
        end else if (s < -(longint'(1) << (AW - 1))) begin
            s   = -(longint'(1) << (AW - 1));
            sat = 1'b1;
        end
`else
        s = wrap_aw(s);
`endif
        return s;
    endfunction

    // One clock: check the DUT against the model at the falling edge, then
    // advance the model across the rising edge with the inputs the bench
    // is driving. Returns #1 after the rising edge.
    task automatic run_cycle();
        bit     exp_ready;
        bit     acc_now;
        bit     is_last;
        longint t;
        longint s;
        longint cnt_n;
        @(negedge clk);
        exp_ready = !bus.clear && (!m_full || bus.out_ready);
        check_output("in_ready", longint'(bus.in_ready), longint'(exp_ready));
        check_output("out_valid", longint'(bus.out_valid), longint'(m_full));
        check_output("fwd_valid", longint'(bus.fwd_valid), longint'(e_fwd_valid));
        check_output("fwd_last", longint'(bus.fwd_last), longint'(e_fwd_last));
        check_output("ifmap_out", longint'(bus.ifmap_out), longint'(e_ifm_out));
        check_output("weight_out", longint'(bus.weight_out), longint'(e_wt_out));
        check_output("sat_flag", longint'(bus.sat_flag), longint'(m_sat));
        acc_now = bus.in_valid && exp_ready;
        is_last = bus.in_last;
        t       = beat_term(bus.ifmap, bus.weight, bus.input_offset);
        @(posedge clk);
        if (rst_n) begin
            m_acc       = 0;
            m_cnt       = 0;
            m_sat       = 1'b0;
            m_full      = 1'b0;
            e_fwd_valid = 1'b0;
            e_fwd_last  = 1'b0;
            e_ifm_out   = '0;
            e_wt_out    = '0;
            exp_q.delete();
            acc_now     = 1'b0;
        end else begin
            if (bus.clear) begin
                m_acc       = 0;
                m_cnt       = 0;
                e_fwd_valid = 1'b0;
                e_fwd_last  = 1'b0;
                e_ifm_out   = '0;
                e_wt_out    = '0;
            end else begin
                e_fwd_valid = acc_now;
                if (acc_now) begin
                    e_ifm_out  = bus.ifmap;
                    e_wt_out   = bus.weight;
                    e_fwd_last = is_last;
                    s     = add_acc(m_acc, t, m_sat);
                    cnt_n = (m_cnt < 65535) ? m_cnt + 1 : 65535;
                    if (is_last) begin
                        exp_q.push_back('{ofmap: s, cnt: cnt_n});
                        m_acc = 0;
                        m_cnt = 0;
                    end else begin
                        m_acc = s;
                        m_cnt = cnt_n;
                    end
                end
            end
            if (acc_now && is_last) m_full = 1'b1;
            else if (m_full && bus.out_ready) m_full = 1'b0;
        end
        last_acc = acc_now;
        #1;
    endtask

    task automatic apply_stimulus(logic [BW-1:0] ifm, logic [BW-1:0] wt,
                                  logic [OW-1:0] off, bit last);
        int waited;
        bus.in_valid     = 1'b1;
        bus.ifmap        = ifm;
        bus.weight       = wt;
        bus.input_offset = off;
        bus.in_last      = last;
        waited           = 0;
        do begin
            run_cycle();
            waited++;
        end while (!last_acc && waited < 50);
        check_output("beat_accept_timeout", longint'(last_acc), 1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic idle(int n);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (n) run_cycle();
    endtask

    // Result scoreboard: a result leaves the DUT on any edge where it is
    // both offered and accepted.
    initial begin
        result_t r;
        forever begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("[TB] FAIL unexpected_result: got ofmap=%0d, expected no result",
                             $signed(bus.ofmap));
                end else begin
                    r = exp_q.pop_front();
                    check_output("ofmap", longint'($signed(bus.ofmap)), r.ofmap);
                    check_output("ofmap_cnt", longint'(bus.ofmap_cnt), r.cnt);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        m_acc = 0; m_cnt = 0; m_sat = 1'b0; m_full = 1'b0;
        e_fwd_valid = 1'b0; e_fwd_last = 1'b0; e_ifm_out = '0; e_wt_out = '0;
        last_acc = 1'b0;
        rst_n            = 1'b1;
        bus.input_offset = '0;
        bus.ifmap        = '0;
        bus.weight       = '0;
        bus.in_valid     = 1'b0;
        bus.in_last      = 1'b0;
        bus.clear        = 1'b0;
        bus.out_ready    = 1'b0;
        @(posedge clk);
        #1;
        idle(2);
        rst_n = 1'b0;

        $display("[TB] reset with a pending result and a beat in flight");
        apply_stimulus(32'h05050505, 32'h03030303, 9'd0, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b0;
        rst_n        = 1'b1;
        repeat (2) run_cycle();
        rst_n = 1'b0;
        check_output("rst_ofmap", longint'(bus.ofmap), 0);
        check_output("rst_ofmap_cnt", longint'(bus.ofmap_cnt), 0);
        check_output("rst_out_valid", longint'(bus.out_valid), 0);
        check_output("rst_in_ready", longint'(bus.in_ready), 1);
        check_output("rst_fwd_valid", longint'(bus.fwd_valid), 0);
        check_output("rst_ifmap_out", longint'(bus.ifmap_out), 0);
        apply_stimulus(32'h11111111, 32'h22222222, 9'd7, 1'b0);
        bus.in_valid = 1'b1;
        rst_n        = 1'b1;
        run_cycle();
        rst_n = 1'b0;
        idle(1);

        $display("[TB] three-beat dot product");
        apply_stimulus(32'h04030201, 32'h01010101, 9'd0, 1'b0);
        apply_stimulus(32'h04030201, 32'h01010101, 9'd0, 1'b0);
        apply_stimulus(32'h04030201, 32'h01010101, 9'd0, 1'b1);
        check_output("dot3_ofmap", longint'($signed(bus.ofmap)), 30);
        check_output("dot3_ofmap_cnt", longint'(bus.ofmap_cnt), 3);
        check_output("dot3_out_valid", longint'(bus.out_valid), 1);
        bus.out_ready = 1'b1;
        idle(1);

        $display("[TB] negative offset");
        apply_stimulus(32'h7F7F7F7F, 32'hFEFEFEFE, 9'h180, 1'b1);
        check_output("offset_ofmap", longint'($signed(bus.ofmap)), 8);
        idle(1);

        $display("[TB] output stall and same-cycle replace");
        bus.out_ready = 1'b0;
        apply_stimulus(32'h01010101, 32'h01010101, 9'd0, 1'b1);
        bus.in_valid     = 1'b1;
        bus.in_last      = 1'b1;
        bus.ifmap        = 32'h02020202;
        bus.weight       = 32'h03030303;
        bus.input_offset = 9'd0;
        repeat (3) run_cycle();
        check_output("stall_in_ready", longint'(bus.in_ready), 0);
        check_output("stall_ofmap", longint'($signed(bus.ofmap)), 4);
        bus.out_ready = 1'b1;
        run_cycle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check_output("replace_out_valid", longint'(bus.out_valid), 1);
        check_output("replace_ofmap", longint'($signed(bus.ofmap)), 24);
        idle(1);

        $display("[TB] clear mid-accumulation");
        apply_stimulus(32'h09080706, 32'h01020304, 9'd3, 1'b0);
        apply_stimulus(32'h10203040, 32'h04030201, 9'd1, 1'b0);
        bus.in_valid = 1'b1;
        bus.clear    = 1'b1;
        run_cycle();
        bus.clear = 1'b0;
        check_output("clear_fwd_valid", longint'(bus.fwd_valid), 0);
        apply_stimulus(32'h00000001, 32'h00000005, 9'd0, 1'b1);
        check_output("clear_ofmap", longint'($signed(bus.ofmap)), 5);
        check_output("clear_ofmap_cnt", longint'(bus.ofmap_cnt), 1);
        idle(1);

        $display("[TB] accumulator overflow");
        bus.out_ready = 1'b0;
        apply_stimulus(32'h7F7F7F7F, 32'h20202020, 9'd0, 1'b0);
        apply_stimulus(32'h7F7F7F7F, 32'h20202020, 9'd0, 1'b0);
        apply_stimulus(32'h7F7F7F7F, 32'h20202020, 9'd0, 1'b1);
`ifdef PE_ACC_SAT_EN
        check_output("ovf_ofmap", longint'($signed(bus.ofmap)), 32767);
        check_output("ovf_sat_flag", longint'(bus.sat_flag), 1);
`else
        check_output("ovf_ofmap", longint'($signed(bus.ofmap)), -16768);
        check_output("ovf_sat_flag", longint'(bus.sat_flag), 0);
`endif
        bus.out_ready = 1'b1;
        idle(1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 800; i++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.clear     = ($urandom_range(0, 24) == 0);
            if (!bus.in_valid || last_acc) begin
                bus.in_valid     = ($urandom_range(0, 3) != 0);
                bus.in_last      = ($urandom_range(0, 3) == 0);
                bus.ifmap        = BW'($urandom);
                bus.weight       = BW'($urandom);
                bus.input_offset = OW'($urandom);
            end
            run_cycle();
        end
        bus.clear     = 1'b0;
        bus.out_ready = 1'b1;
        idle(3);
        check_output("results_drained", longint'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
